// File: rtl/seq_gate_pkg.sv
// Shared types and constants for the seq_gate sequence/password checker.
// Widths that depend on the instance's MAX_LEN are derived through the helpers below.
package seq_gate_pkg;

  localparam int DEF_MAX_LEN = 32;
  localparam int IDX_W       = $clog2(DEF_MAX_LEN + 1);
  localparam int CNT_W       = 8;

  localparam int MODE_FRAME  = 0;
  localparam int MODE_STREAM = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MATCH,
    ST_LOCK
  } gate_state_e;

  // A zero-cycle lockout still needs a 1-bit counter to hold the "never expires" value.
  function automatic int timer_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/seq_gate_lock_timer.sv
// Lockout countdown: loads LOAD_VAL, counts down while running, and flags the
// cycle in which the count steps from 1 to 0. A load of 0 never expires.
module seq_gate_lock_timer
  import seq_gate_pkg::*;
#(
  parameter int LOAD_VAL = 1024
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic i_load,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int TW = timer_width(LOAD_VAL);

  logic [TW-1:0] r_count;

  assign o_expire = i_run && (r_count == TW'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= TW'(LOAD_VAL);
    end else if (i_run && (r_count != '0)) begin
      r_count <= r_count - TW'(1);
    end
  end

endmodule

// File: rtl/seq_gate.sv
// Programmable sequence gate: frame mode checks each delimited attempt exactly and
// locks out after repeated failures; stream mode searches for the pattern anywhere.
module seq_gate
  import seq_gate_pkg::*;
#(
  parameter int W           = 8,
  parameter int MAX_LEN     = 32,
  parameter int STREAM      = 0,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [W-1:0]                 BYTE,
  input  logic                         BYTE_VALID,
  input  logic                         BYTE_LAST,
  input  logic                         PROG_WE,
  input  logic [$clog2(MAX_LEN)-1:0]   PROG_ADDR,
  input  logic [W-1:0]                 PROG_DATA,
  input  logic                         PROG_LEN_WE,
  input  logic [$clog2(MAX_LEN+1)-1:0] PROG_LEN,
  input  logic                         CLEAR,
  output logic                         GOOD,
  output logic                         FAIL,
  output logic                         LOCKED,
  output logic [$clog2(MAX_LEN+1)-1:0] MATCH_IDX,
  output logic [CNT_W-1:0]             FAIL_CNT
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [W-1:0]     r_pattern [MAX_LEN];
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic             r_ok;
  logic             r_good;
  logic             r_fail;
  logic [CNT_W-1:0] r_fail_cnt;
  gate_state_e      r_state;

  logic [LEN_W-1:0]  w_idx_nxt;
  logic              w_ok_nxt;
  logic              w_good_nxt;
  logic              w_fail_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_lock_nxt;
  gate_state_e       w_state_nxt;
  logic              w_load;
  logic              w_tclr;
  logic              w_expire;
  logic              w_locked;
  logic              w_prog;
  logic              w_accept;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_sym_eq;
  logic              w_seed;
  logic              w_hit;
  logic              w_at_end;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_locked  = (r_state == ST_LOCK);
  assign w_prog    = PROG_WE || PROG_LEN_WE;
  assign w_accept  = BYTE_VALID && !w_locked;
  // idx may sit at MAX_LEN after an over-long frame; keep the read in range.
  assign w_rd_addr = (r_idx < LEN_MAX) ? r_idx[ADDR_W-1:0] : '0;
  assign w_sym_eq  = (BYTE == r_pattern[w_rd_addr]);
  assign w_seed    = (BYTE == r_pattern[0]);
  assign w_hit     = r_ok && (r_idx < r_len) && w_sym_eq;
  assign w_at_end  = (r_idx == r_len - LEN_W'(1));
  assign w_cnt_inc = (r_fail_cnt == '1) ? r_fail_cnt : r_fail_cnt + CNT_W'(1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_ok_nxt   = r_ok;
    w_good_nxt = (STREAM == MODE_STREAM) ? 1'b0 : r_good;
    w_fail_nxt = 1'b0;
    w_cnt_nxt  = r_fail_cnt;
    w_lock_nxt = w_locked;
    w_load     = 1'b0;
    w_tclr     = 1'b0;

    if (CLEAR) begin
      w_idx_nxt  = '0;
      w_ok_nxt   = 1'b1;
      w_good_nxt = 1'b0;
      w_cnt_nxt  = '0;
      w_lock_nxt = 1'b0;
      w_tclr     = 1'b1;
    end else begin
      if (w_expire) begin
        w_lock_nxt = 1'b0;
        w_cnt_nxt  = '0;
      end
      if (w_prog) begin
        w_idx_nxt  = '0;
        w_ok_nxt   = 1'b1;
        w_good_nxt = 1'b0;
      end else if (w_accept) begin
        if (STREAM == MODE_STREAM) begin
          if (w_sym_eq) begin
            if (w_at_end) begin
              w_good_nxt = 1'b1;
              w_idx_nxt  = '0;
            end else begin
              w_idx_nxt = r_idx + LEN_W'(1);
            end
          end else begin
            w_idx_nxt = w_seed ? LEN_W'(1) : '0;
          end
        end else begin
          w_good_nxt = 1'b0;
          if (!BYTE_LAST) begin
            w_ok_nxt  = w_hit;
            w_idx_nxt = (r_idx == LEN_MAX) ? r_idx : r_idx + LEN_W'(1);
          end else begin
            if (w_hit && w_at_end) begin
              w_good_nxt = 1'b1;
              w_cnt_nxt  = '0;
            end else begin
              w_fail_nxt = 1'b1;
              w_cnt_nxt  = w_cnt_inc;
              if (w_cnt_inc >= CNT_W'(MAX_FAIL)) begin
                w_lock_nxt = 1'b1;
                w_load     = 1'b1;
              end
            end
            w_idx_nxt = '0;
            w_ok_nxt  = 1'b1;
          end
        end
      end
    end

    if (w_lock_nxt)              w_state_nxt = ST_LOCK;
    else if (w_idx_nxt != '0)    w_state_nxt = ST_MATCH;
    else                         w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_idx      <= '0;
      r_ok       <= 1'b1;
      r_good     <= 1'b0;
      r_fail     <= 1'b0;
      r_fail_cnt <= '0;
      r_state    <= ST_IDLE;
    end else begin
      r_idx      <= w_idx_nxt;
      r_ok       <= w_ok_nxt;
      r_good     <= w_good_nxt;
      r_fail     <= w_fail_nxt;
      r_fail_cnt <= w_cnt_nxt;
      r_state    <= w_state_nxt;
    end
  end

  // NOTE: the pattern file is reset on purpose: a fresh device must start from a known all-zero key.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < MAX_LEN; i++) r_pattern[i] <= '0;
      r_len <= LEN_W'(1);
    end else if (!CLEAR) begin
      if (PROG_WE) r_pattern[PROG_ADDR] <= PROG_DATA;
      if (PROG_LEN_WE && (PROG_LEN != '0)) begin
        r_len <= (PROG_LEN > LEN_MAX) ? LEN_MAX : PROG_LEN;
      end
    end
  end

  seq_gate_lock_timer #(
    .LOAD_VAL(LOCK_CYCLES)
  ) u_lock_timer (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .i_load  (w_load),
    .i_clear (w_tclr),
    .i_run   (w_locked),
    .o_expire(w_expire)
  );

  assign GOOD      = r_good;
  assign FAIL      = r_fail;
  assign LOCKED    = w_locked;
  assign MATCH_IDX = r_idx;
  assign FAIL_CNT  = r_fail_cnt;

endmodule
